// File: rtl/psum_norm_pkg.sv
// Shared types and helpers for the multi-channel partial-sum normalizer.
package psum_norm_pkg;

  typedef enum logic [1:0] {IDLE, SUM, DIV, OUT} state_t;

  // Accumulator width that holds the sum of n_ch*col signed elements exactly.
  function automatic int acc_width(input int bw_psum, input int n_ch, input int col);
    return bw_psum + $clog2(n_ch * col);
  endfunction

  // Clamp a signed value into the signed range of 'width' bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
  endfunction

  // Half-LSB rounding offset for a right shift by 'shift' bits (none when shift is 0).
  function automatic longint round_term(input int shift);
    if (shift > 0) return longint'(1) << (shift - 1);
    return 0;
  endfunction

endpackage

// File: rtl/seq_udiv.sv
// Restoring unsigned divider, one quotient bit per cycle.
// The first bit is resolved in the start cycle itself and done is raised
// combinationally while the last bit is resolved, with quot showing the
// final quotient in that same cycle; a W_NUM-bit quotient thus takes
// exactly W_NUM cycles from start to done inclusive.
module seq_udiv #(
  parameter int W_NUM = 17,
  parameter int W_DEN = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W_NUM-1:0] num,
  input  logic [W_DEN-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [W_NUM-1:0] quot
);

  localparam int CW = $clog2(W_NUM + 1);

  logic [W_DEN-1:0] r_rem;
  logic [W_DEN-1:0] r_den;
  logic [W_NUM-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;

  logic [W_DEN-1:0] w_rem_in;
  logic [W_DEN-1:0] w_den_in;
  logic [W_NUM-1:0] w_q_in;
  logic [W_DEN:0]   w_trial;
  logic             w_ge;
  logic [W_DEN-1:0] w_rem_next;
  logic [W_NUM-1:0] w_q_next;

  // One restoring step on either fresh operands (start) or the running state.
  always_comb begin
    w_rem_in   = start ? '0 : r_rem;
    w_den_in   = start ? den : r_den;
    w_q_in     = start ? num : r_q;
    w_trial    = {w_rem_in, w_q_in[W_NUM-1]};
    w_ge       = (w_trial >= {1'b0, w_den_in});
    w_rem_next = w_ge ? W_DEN'(w_trial - {1'b0, w_den_in}) : w_trial[W_DEN-1:0];
    w_q_next   = {w_q_in[W_NUM-2:0], w_ge};
  end

  // Iteration state: load and first step on start, then one step per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem  <= '0;
      r_den  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_rem  <= w_rem_next;
      r_den  <= den;
      r_q    <= w_q_next;
      r_cnt  <= CW'(W_NUM - 1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= w_rem_next;
      r_q   <= w_q_next;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

  assign busy = r_busy;
  assign done = r_busy && (r_cnt == CW'(1));
  assign quot = w_q_next;

endmodule

// File: rtl/psum_normalizer_mc.sv
// Multi-channel partial-sum normalizer: sums one beat of N_CH x COL psums,
// takes one reciprocal of |S|, then streams x/S in fixed point lane by lane.
// Build option: define NORM_ROUND_EN for round-half-up before the final
// shift; otherwise the shift truncates toward -inf.
module psum_normalizer_mc
  import psum_norm_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int COL       = 8,
  parameter int BW_PSUM   = 16,
  parameter int W_OUT     = 16,
  parameter int FRAC_BITS = 8,
  parameter int RECIP_W   = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [N_CH-1:0][COL-1:0][BW_PSUM-1:0] s_data,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [N_CH-1:0][W_OUT-1:0]            m_data,
  output logic                                  m_last,
  output logic                                  div_zero,
  output logic                                  busy
);

  localparam int AW = acc_width(BW_PSUM, N_CH, COL);
  localparam int PW = BW_PSUM + RECIP_W + 2;
  localparam int SH = RECIP_W - FRAC_BITS;
  localparam int CW = $clog2(COL);
  localparam logic [CW-1:0]    CNT_LAST = CW'(COL - 1);
  localparam logic [RECIP_W:0] DIV_NUM  = {1'b1, {RECIP_W{1'b0}}};

  state_t r_state;
  state_t w_state_next;

  logic [N_CH-1:0][COL-1:0][BW_PSUM-1:0] r_data;
  logic signed [AW-1:0]                  r_acc;
  logic [CW-1:0]                         r_cnt;
  logic [RECIP_W:0]                      r_recip;
  logic                                  r_sign;
  logic                                  r_m_valid;
  logic                                  r_m_last;
  logic                                  r_div_zero;
  logic [N_CH-1:0][W_OUT-1:0]            r_m_data;

  logic signed [AW-1:0] w_lane_sum;
  logic [AW-1:0]        w_acc_abs;
  logic                 w_acc_zero;
  logic                 w_hs;
  logic                 w_div_start;
  logic                 w_div_busy;
  logic                 w_div_done;
  logic [RECIP_W:0]     w_quot;
  logic [W_OUT-1:0]     w_y [N_CH];

  assign w_hs       = r_m_valid && m_ready;
  assign w_acc_zero = (r_acc == '0);
  assign w_acc_abs  = r_acc[AW-1] ? $unsigned(-r_acc) : $unsigned(r_acc);

  // Sign-extended sum of lane 0 across all channels.
  always_comb begin
    w_lane_sum = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_lane_sum = w_lane_sum + AW'($signed(r_data[c][0]));
    end
  end

  seq_udiv #(
    .W_NUM(RECIP_W + 1),
    .W_DEN(AW)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .start(w_div_start),
    .num  (DIV_NUM),
    .den  (w_acc_abs),
    .busy (w_div_busy),
    .done (w_div_done),
    .quot (w_quot)
  );

  // Per-channel scaling: lane 0 normally, lane 1 when a handshake rotates
  // the data this cycle so the next beat is registered without a bubble.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic signed [BW_PSUM-1:0] w_x;
    logic signed [PW-1:0]      w_p;
    logic signed [PW-1:0]      w_ps;
    logic signed [PW-1:0]      w_pr;
    logic signed [PW-1:0]      w_sh;

    assign w_x  = w_hs ? r_data[gi][1] : r_data[gi][0];
    assign w_p  = PW'(w_x) * $signed({{(PW - RECIP_W - 1){1'b0}}, r_recip});
    assign w_ps = r_sign ? -w_p : w_p;
`ifdef NORM_ROUND_EN
    localparam logic signed [PW-1:0] ROUND = PW'(round_term(SH));
    assign w_pr = w_ps + ROUND;
`else
    assign w_pr = w_ps;
`endif
    assign w_sh = w_pr >>> SH;
    assign w_y[gi] = W_OUT'(sat_signed(64'(w_sh), W_OUT));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next state, input ready, busy flag and divider launch.
  always_comb begin
    w_state_next = r_state;
    s_ready      = 1'b0;
    busy         = 1'b1;
    w_div_start  = 1'b0;
    case (r_state)
      IDLE: begin
        busy    = 1'b0;
        s_ready = !reset;
        if (s_valid && !reset) w_state_next = SUM;
      end
      SUM: if (r_cnt == CNT_LAST) w_state_next = DIV;
      DIV: begin
        if (w_acc_zero) begin
          w_state_next = OUT;
        end else begin
          w_div_start = !w_div_busy;
          if (w_div_done) w_state_next = OUT;
        end
      end
      OUT: if (w_hs && (r_cnt == CNT_LAST)) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: capture, accumulate with rotation, reciprocal latch, output beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data     <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_recip    <= '0;
      r_sign     <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_div_zero <= 1'b0;
      r_m_data   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_valid) begin
            r_data <= s_data;
            r_acc  <= '0;
            r_cnt  <= '0;
          end
        end
        SUM: begin
          r_acc <= r_acc + w_lane_sum;
          for (int c = 0; c < N_CH; c++)
            for (int j = 0; j < COL; j++)
              r_data[c][j] <= r_data[c][(j + 1) % COL];
          r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
        end
        DIV: begin
          r_cnt  <= '0;
          r_sign <= r_acc[AW-1];
          if (w_acc_zero) begin
            r_div_zero <= 1'b1;
            r_recip    <= '0;
          end else if (w_div_done) begin
            r_recip <= w_quot;
          end
        end
        OUT: begin
          if (!r_m_valid) begin
            for (int c = 0; c < N_CH; c++) r_m_data[c] <= w_y[c];
            r_m_valid <= 1'b1;
            r_m_last  <= 1'b0;
          end else if (m_ready) begin
            for (int c = 0; c < N_CH; c++)
              for (int j = 0; j < COL; j++)
                r_data[c][j] <= r_data[c][(j + 1) % COL];
            if (r_cnt == CNT_LAST) begin
              r_m_valid  <= 1'b0;
              r_m_last   <= 1'b0;
              r_div_zero <= 1'b0;
              r_m_data   <= '0;
            end else begin
              for (int c = 0; c < N_CH; c++) r_m_data[c] <= w_y[c];
              r_cnt    <= r_cnt + 1'b1;
              r_m_last <= (r_cnt == CW'(COL - 2));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign m_valid  = r_m_valid;
  assign m_last   = r_m_last;
  assign div_zero = r_div_zero;
  assign m_data   = r_m_data;

endmodule

// File: tb/tb_psum_normalizer_mc.sv
// Directed self-checking bench for psum_normalizer_mc (N_CH=2, COL=4).
module tb_psum_normalizer_mc;

  logic                  clk;
  logic                  reset;
  logic                  s_valid;
  logic                  s_ready;
  logic [1:0][3:0][15:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [1:0][15:0]      m_data;
  logic                  m_last;
  logic                  div_zero;
  logic                  busy;

  int n_checks;
  int n_fail;

  psum_normalizer_mc #(
    .N_CH(2), .COL(4), .BW_PSUM(16), .W_OUT(16), .FRAC_BITS(8), .RECIP_W(16)
  ) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .div_zero(div_zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends one set, measures accept-to-first-valid latency, collects 4 beats.
  task automatic run_set(input int c0[4], input int c1[4], output int lat,
                         output int o0[4], output int o1[4],
                         output logic lst[4], output logic dz[4], output bit tmo);
    int n;
    tmo = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data[0][i] = 16'(c0[i]);
      s_data[1][i] = 16'(c1[i]);
    end
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!s_ready) tmo = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    lat = 1;
    while (!m_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!m_valid && n < 50) begin @(posedge clk); #1; n++; end
      if (!m_valid) tmo = 1'b1;
      o0[k]  = int'($signed(m_data[0]));
      o1[k]  = int'($signed(m_data[1]));
      lst[k] = m_last;
      dz[k]  = div_zero;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    n_checks++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL reset_m_data got %h want 0", m_data); end
    n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last got %b want 0", m_last); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0;
    #1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL release_s_ready got %b want 1", s_ready); end
    $display("test_reset done");
  endtask

  // Runs one set and compares latency and every beat against the given expectation.
  task automatic check_set(input string name, input int c0[4], input int c1[4],
                           input int e_lat, input int e0[4], input int e1[4], input logic e_dz);
    int lat;
    int o0[4];
    int o1[4];
    logic lst[4];
    logic dz[4];
    bit tmo;
    run_set(c0, c1, lat, o0, o1, lst, dz, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL %s_timeout got expired want none", name); end
    n_checks++; if (lat != e_lat) begin n_fail++; $display("FAIL %s_latency got %0d want %0d", name, lat, e_lat); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (o0[k] != e0[k]) begin n_fail++; $display("FAIL %s_ch0_beat%0d got %0d want %0d", name, k, o0[k], e0[k]); end
      n_checks++; if (o1[k] != e1[k]) begin n_fail++; $display("FAIL %s_ch1_beat%0d got %0d want %0d", name, k, o1[k], e1[k]); end
      n_checks++; if (lst[k] !== (k == 3)) begin n_fail++; $display("FAIL %s_last_beat%0d got %b want %b", name, k, lst[k], (k == 3)); end
      n_checks++; if (dz[k] !== e_dz) begin n_fail++; $display("FAIL %s_div_zero_beat%0d got %b want %b", name, k, dz[k], e_dz); end
    end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL %s_m_valid_after got %b want 0", name, m_valid); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL %s_div_zero_after got %b want 0", name, div_zero); end
    $display("%s: latency %0d ch0 %0d %0d %0d %0d ch1 %0d %0d %0d %0d", name, lat,
             o0[0], o0[1], o0[2], o0[3], o1[0], o1[1], o1[2], o1[3]);
  endtask

  task automatic test_ones();
    int c[4] = '{1, 1, 1, 1};
    int e[4] = '{32, 32, 32, 32};
    check_set("ones", c, c, 23, e, e, 1'b0);
  endtask

  task automatic test_ramp();
    int c0[4] = '{10, 20, 30, 40};
    int z[4]  = '{0, 0, 0, 0};
`ifdef NORM_ROUND_EN
    int e0[4] = '{26, 51, 77, 102};
`else
    int e0[4] = '{25, 51, 76, 102};
`endif
    check_set("ramp", c0, z, 23, e0, z, 1'b0);
  endtask

  task automatic test_negative();
    int c0[4] = '{-4, 0, 0, 0};
    int z[4]  = '{0, 0, 0, 0};
    int e0[4] = '{256, 0, 0, 0};
    check_set("negative", c0, z, 23, e0, z, 1'b0);
  endtask

  task automatic test_zero();
    int z[4] = '{0, 0, 0, 0};
    check_set("zero", z, z, 7, z, z, 1'b1);
  endtask

  task automatic test_saturation();
    int c0[4] = '{200, -199, 0, 0};
    int z[4]  = '{0, 0, 0, 0};
    int e0[4] = '{32767, -32768, 0, 0};
    check_set("saturation", c0, z, 23, e0, z, 1'b0);
  endtask

  // S=16 -> recip=4096 -> out = 16*x exactly; beat 1 is stalled for 3 cycles.
  task automatic test_backpressure();
    int c0[4] = '{1, 2, 3, 2};
    int c1[4] = '{0, 4, 0, 4};
    int n;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data[0][i] = 16'(c0[i]);
      s_data[1][i] = 16'(c1[i]);
    end
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 100) begin @(posedge clk); #1; n++; end
    n_checks++; if (!m_valid) begin n_fail++; $display("FAIL bp_timeout got no m_valid want m_valid"); end
    n_checks++; if (m_data !== {16'd0, 16'd16}) begin n_fail++; $display("FAIL bp_beat0 got %h want 00000010", m_data); end
    @(posedge clk); #1;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid%0d got %b want 1", i, m_valid); end
      n_checks++; if (m_data !== {16'd64, 16'd32}) begin n_fail++; $display("FAIL bp_hold_data%0d got %h want 00400020", i, m_data); end
      n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL bp_hold_last%0d got %b want 0", i, m_last); end
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_s_ready%0d got %b want 0", i, s_ready); end
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (m_data !== {16'd0, 16'd48}) begin n_fail++; $display("FAIL bp_beat2 got %h want 00000030", m_data); end
    n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL bp_beat2_last got %b want 0", m_last); end
    @(posedge clk); #1;
    n_checks++; if (m_data !== {16'd64, 16'd32}) begin n_fail++; $display("FAIL bp_beat3 got %h want 00400020", m_data); end
    n_checks++; if (m_last !== 1'b1) begin n_fail++; $display("FAIL bp_beat3_last got %b want 1", m_last); end
    @(posedge clk); #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done_valid got %b want 0", m_valid); end
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid_sum();
    int c[4] = '{9, 9, 9, 9};
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data[0][i] = 16'(c[i]);
      s_data[1][i] = 16'(c[i]);
    end
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before got %b want 1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_m_valid got %b want 0", m_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_s_ready got %b want 0", s_ready); end
    reset = 1'b0;
    #1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_release got %b want 1", s_ready); end
    $display("test_reset_mid_sum: reset applied in SUM");
    test_ones();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_ones();
    test_ramp();
    test_negative();
    test_zero();
    test_saturation();
    test_backpressure();
    test_reset_mid_sum();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
